// File: rtl/term_pkg.sv
// Shared terminal definitions: character codes, screen geometry, writer FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a. Also imported by the display scanner for geometry and first_line semantics.
package term_pkg;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_HT    = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int TERM_COLS = 64;
    localparam int TERM_ROWS = 16;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } wr_state_t;

    // Logical screen row -> physical buffer row. first_line is the physical
    // row shown at the top of the screen, so the 4-bit sum wraps naturally.
    function automatic logic [3:0] phys_row(input logic [3:0] y, input logic [3:0] fl);
        return y + fl;
    endfunction

endpackage

// File: rtl/term_writer.sv
// Terminal writer: ASCII stream (printable, CR, LF, BS[, HT]) -> 1k x 8 character buffer writes, hardware scroll.
// Latency: accepted byte -> registered buffer write and cursor update one cycle later; scroll clears 64 cells over 64 cycles.
// Backpressure: in_ready high only in IDLE; low during the 1024-cycle power-on clear and the 64-cycle line clear.
//
// Ports: clk, reset_n (async, active low); in_data/in_valid/in_ready byte stream;
//        buf_addr {phys_row, col}, buf_din, buf_we to the buffer write port;
//        first_line (to display scanner), cursor_x, cursor_y.
// Build option: define TERM_WRITER_TAB_EN to make 0x09 advance to the next multiple-of-8 column.
module term_writer
    import term_pkg::*;
#(
    parameter int         COLS      = TERM_COLS,
    parameter int         ROWS      = TERM_ROWS,
    parameter logic [7:0] FILL_CHAR = CHAR_SPACE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] buf_addr,
    output logic [7:0] buf_din,
    output logic       buf_we,
    output logic [3:0] first_line,
    output logic [5:0] cursor_x,
    output logic [3:0] cursor_y
);

    localparam logic [5:0] X_MAX = 6'(COLS - 1);
    localparam logic [3:0] Y_MAX = 4'(ROWS - 1);

    wr_state_t  state, state_nxt;
    logic [9:0] clr_cnt, cnt_nxt;
    logic [9:0] addr_nxt;
    logic [7:0] din_nxt;
    logic       we_nxt;
    logic [5:0] cx_nxt;
    logic [3:0] cy_nxt;
    logic [3:0] fl_nxt;

`ifdef TERM_WRITER_TAB_EN
    // One extra bit catches the step past the last tab stop (56..63 -> 64).
    logic [6:0] tab_sum;
    assign tab_sum = {1'b0, cursor_x | 6'd7} + 7'd1;
`endif

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        we_nxt    = 1'b0;
        addr_nxt  = buf_addr;
        din_nxt   = buf_din;
        cx_nxt    = cursor_x;
        cy_nxt    = cursor_y;
        fl_nxt    = first_line;

        case (state)
            CLEAR_ALL: begin
                // The counter wraps to 0 after issuing addr 1023; a pending
                // write with a zero counter therefore means the sweep is done.
                if (buf_we && clr_cnt == 10'd0) begin
                    state_nxt = IDLE;
                end else begin
                    we_nxt   = 1'b1;
                    addr_nxt = clr_cnt;
                    din_nxt  = FILL_CHAR;
                    cnt_nxt  = clr_cnt + 10'd1;
                end
            end

            CLEAR_LINE: begin
                // Column 0 was issued on entry with the counter preloaded to 1,
                // so low bits back at 0 means column 63 has been presented.
                // The row is held in buf_addr's upper bits throughout.
                if (clr_cnt[5:0] == 6'd0) begin
                    state_nxt = IDLE;
                end else begin
                    we_nxt   = 1'b1;
                    addr_nxt = {buf_addr[9:6], clr_cnt[5:0]};
                    din_nxt  = FILL_CHAR;
                    cnt_nxt  = clr_cnt + 10'd1;
                end
            end

            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        we_nxt   = 1'b1;
                        addr_nxt = {phys_row(cursor_y, first_line), cursor_x};
                        din_nxt  = in_data;
                        if (cursor_x < X_MAX)
                            cx_nxt = cursor_x + 6'd1;
                    end else if (in_data == CHAR_CR) begin
                        cx_nxt = 6'd0;
                    end else if (in_data == CHAR_LF) begin
                        if (cursor_y < Y_MAX) begin
                            cy_nxt = cursor_y + 4'd1;
                        end else begin
                            // Old top row becomes the new bottom row; clear it.
                            fl_nxt    = first_line + 4'd1;
                            state_nxt = CLEAR_LINE;
                            we_nxt    = 1'b1;
                            addr_nxt  = {first_line, 6'd0};
                            din_nxt   = FILL_CHAR;
                            cnt_nxt   = 10'd1;
                        end
                    end else if (in_data == CHAR_BS) begin
                        if (cursor_x != 6'd0)
                            cx_nxt = cursor_x - 6'd1;
`ifdef TERM_WRITER_TAB_EN
                    end else if (in_data == CHAR_HT) begin
                        cx_nxt = tab_sum[6] ? X_MAX : tab_sum[5:0];
`endif
                    end
                end
            end

            default: state_nxt = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR_ALL;
            clr_cnt    <= 10'd0;
            buf_we     <= 1'b0;
            buf_addr   <= 10'd0;
            buf_din    <= 8'd0;
            first_line <= 4'd0;
            cursor_x   <= 6'd0;
            cursor_y   <= 4'd0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= cnt_nxt;
            buf_we     <= we_nxt;
            buf_addr   <= addr_nxt;
            buf_din    <= din_nxt;
            first_line <= fl_nxt;
            cursor_x   <= cx_nxt;
            cursor_y   <= cy_nxt;
        end
    end

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: power-on clear, printable writes, CR/LF/BS, scroll, discard, tab, mid-clear reset.
// Latency: n/a (testbench).
// Backpressure: byte sender waits on in_ready with a bounded budget.
module tb_term_writer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] buf_addr;
    logic [7:0] buf_din;
    logic       buf_we;
    logic [3:0] first_line;
    logic [5:0] cursor_x;
    logic [3:0] cursor_y;

    term_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .buf_addr   (buf_addr),
        .buf_din    (buf_din),
        .buf_we     (buf_we),
        .first_line (first_line),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Write log, sampled just after each rising edge.
    logic [9:0] wr_addr[$];
    logic [7:0] wr_dat[$];
    int         wr_cyc[$];
    int         cyc = 0;
    int         rdy_low = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (buf_we) begin
            wr_addr.push_back(buf_addr);
            wr_dat.push_back(buf_din);
            wr_cyc.push_back(cyc);
        end
        if (reset_n && !in_ready)
            rdy_low = rdy_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_dat.delete();
        wr_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] b, input int count);
        for (int i = 0; i < count; i++) send(b);
    endtask

    // Release reset at a negedge and verify the full power-on sweep.
    task automatic release_and_check_clear(input string tag);
        int n;
        int bad;
        clear_log();
        reset_n = 1'b1;
        n = 0;
        while (!in_ready && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_cycle"}, 32'(n), 32'd1025);
        check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd1024);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != 10'(i) || wr_dat[i] != 8'h20) bad++;
            if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) bad++;
        end
        check({tag, "_sweep_bad"}, 32'(bad), 32'd0);
        check({tag, "_cursor"}, {22'd0, cursor_y, cursor_x}, 32'd0);
        check({tag, "_first_line"}, 32'(first_line), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(buf_we), 32'd0);
        check({tag, "_addr"}, 32'(buf_addr), 32'd0);
        check({tag, "_din"}, 32'(buf_din), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_fl"}, 32'(first_line), 32'd0);
        check({tag, "_cxy"}, {22'd0, cursor_y, cursor_x}, 32'd0);
    endtask

    initial begin
        int bad;
        logic [5:0] exp_col;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_and_check_clear("clr1");

        // "AB" back to back
        clear_log();
        rdy_low = 0;
        send(8'h41);
        send(8'h42);
        check("ab_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("ab_a_addr", 32'(wr_addr[0]), 32'd0);
            check("ab_a_dat", 32'(wr_dat[0]), 32'h41);
            check("ab_b_addr", 32'(wr_addr[1]), 32'd1);
            check("ab_b_dat", 32'(wr_dat[1]), 32'h42);
            check("ab_consecutive", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
        end
        check("ab_cx", 32'(cursor_x), 32'd2);
        check("ab_rdy_low", 32'(rdy_low), 32'd0);

        // 70 x 'X' from column 0: saturate at column 63
        send(8'h0D);
        check("cr_cx", 32'(cursor_x), 32'd0);
        clear_log();
        send_n(8'h58, 70);
        check("x70_nwrites", 32'(wr_addr.size()), 32'd70);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            exp_col = (i < 63) ? 6'(i) : 6'd63;
            if (wr_addr[i] != {4'd0, exp_col} || wr_dat[i] != 8'h58) bad++;
        end
        check("x70_bad", 32'(bad), 32'd0);
        check("x70_cx", 32'(cursor_x), 32'd63);
        check("x70_cy", 32'(cursor_y), 32'd0);

        // CR + 15 LF: cursor_y reaches 15 without scrolling
        send(8'h0D);
        clear_log();
        send_n(8'h0A, 15);
        check("lf15_cy", 32'(cursor_y), 32'd15);
        check("lf15_fl", 32'(first_line), 32'd0);
        check("lf15_nwrites", 32'(wr_addr.size()), 32'd0);

        // 16th LF scrolls and clears physical row 0
        clear_log();
        rdy_low = 0;
        send(8'h0A);
        check("scroll_fl", 32'(first_line), 32'd1);
        check("scroll_cy", 32'(cursor_y), 32'd15);
        begin
            int n;
            n = 0;
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("scroll_ready_wait", 32'(n < 200), 32'd1);
        end
        check("scroll_nwrites", 32'(wr_addr.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != 10'(i) || wr_dat[i] != 8'h20) bad++;
            if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) bad++;
        end
        check("scroll_bad", 32'(bad), 32'd0);
        check("scroll_rdy_low", 32'(rdy_low), 32'd64);

        // 'Z' lands on the new bottom row = physical row 0
        clear_log();
        send(8'h5A);
        check("z_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("z_addr", 32'(wr_addr[0]), 32'd0);
            check("z_dat", 32'(wr_dat[0]), 32'h5A);
        end
        check("z_cx", 32'(cursor_x), 32'd1);

        // BS x6 from column 5 stops at 0
        send(8'h0D);
        send_n(8'h61, 5);
        check("bs_pre_cx", 32'(cursor_x), 32'd5);
        clear_log();
        send_n(8'h08, 6);
        check("bs_cx", 32'(cursor_x), 32'd0);
        check("bs_nwrites", 32'(wr_addr.size()), 32'd0);

        // Discarded bytes
        send_n(8'h61, 2);
        clear_log();
        send(8'h07);
        send(8'hC1);
        send(8'h7F);
        check("disc_cx", 32'(cursor_x), 32'd2);
        check("disc_cy", 32'(cursor_y), 32'd15);
        check("disc_nwrites", 32'(wr_addr.size()), 32'd0);

        // Horizontal tab
        send(8'h0D);
        send_n(8'h62, 3);
        clear_log();
        send(8'h09);
`ifdef TERM_WRITER_TAB_EN
        check("ht3_cx", 32'(cursor_x), 32'd8);
`else
        check("ht3_cx", 32'(cursor_x), 32'd3);
`endif
        send(8'h0D);
        send_n(8'h63, 60);
        clear_log();
        send(8'h09);
`ifdef TERM_WRITER_TAB_EN
        check("ht60_cx", 32'(cursor_x), 32'd63);
`else
        check("ht60_cx", 32'(cursor_x), 32'd60);
`endif
        check("ht_nwrites", 32'(wr_addr.size()), 32'd0);

        // Reset in the middle of a line clear
        send(8'h0A);
        check("midclr_fl", 32'(first_line), 32'd2);
        repeat (10) @(negedge clk);
        check("midclr_busy", 32'(in_ready), 32'd0);
        check("midclr_we", 32'(buf_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        release_and_check_clear("clr2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
